// File: rtl/gpio_pkg.sv
// Shared definitions for the Avalon-MM GPIO slave: register map, edge modes and
// the byte-enable merge helper.
package gpio_pkg;

  localparam logic [1:0] ADDR_DATA_IN  = 2'd0;
  localparam logic [1:0] ADDR_DATA_OUT = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  typedef enum logic [1:0] {
    EdgeRise = 2'd0,
    EdgeFall = 2'd1,
    EdgeAny  = 2'd2
  } edge_mode_e;

  // Replace the bytes of old_val selected by be with the matching bytes of new_val.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = be[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage flip-flop synchronizer for the asynchronous GPIO input pins.
module gpio_sync #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/avalon_gpio_slave.sv
// Avalon-MM GPIO slave: output register, synchronized inputs with edge capture,
// maskable level interrupt and a fixed one-cycle read pipeline.
module avalon_gpio_slave
  import gpio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      EDGE_MODE   = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  input  logic [3:0]       avs_byteenable,
  output logic [31:0]      avs_readdata,
  output logic             avs_readdatavalid,
  output logic             irq,
  input  logic [WIDTH-1:0] gpio_input,
  output logic [WIDTH-1:0] gpio_output
);

  localparam logic [1:0] EdgeModeBits = EDGE_MODE[1:0];
  localparam edge_mode_e EdgeSel      = edge_mode_e'(EdgeModeBits);

  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_bits;
  logic [31:0]      readdata_q, readdata_d;
  logic             rdvalid_q;
  logic             irq_q;

  logic [31:0] in_ext, out_ext, mask_ext, cap_ext;
  logic [31:0] out_merged, mask_merged, be_mask, clr_word;

  gpio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (gpio_input),
    .q_o    (sync_last)
  );

  always_comb begin
    in_ext   = '0;
    out_ext  = '0;
    mask_ext = '0;
    cap_ext  = '0;
    in_ext[WIDTH-1:0]   = sync_last;
    out_ext[WIDTH-1:0]  = out_q;
    mask_ext[WIDTH-1:0] = mask_q;
    cap_ext[WIDTH-1:0]  = cap_q;
  end

  always_comb begin
    unique case (EdgeSel)
      EdgeRise: edge_det = sync_last & ~prev_q;
      EdgeFall: edge_det = ~sync_last & prev_q;
      default:  edge_det = sync_last ^ prev_q;
    endcase
  end

  always_comb begin
    out_merged  = be_merge(out_ext, avs_writedata, avs_byteenable);
    mask_merged = be_merge(mask_ext, avs_writedata, avs_byteenable);
    be_mask     = be_merge(32'h0, 32'hFFFF_FFFF, avs_byteenable);
    clr_word    = avs_writedata & be_mask;

    out_d    = out_q;
    mask_d   = mask_q;
    clr_bits = '0;
    if (avs_write) begin
      unique case (avs_address)
        ADDR_DATA_OUT: out_d    = out_merged[WIDTH-1:0];
        ADDR_IRQ_MASK: mask_d   = mask_merged[WIDTH-1:0];
        ADDR_EDGE_CAP: clr_bits = clr_word[WIDTH-1:0];
        default:       ;
      endcase
    end
    // A new edge wins over a same-cycle clear of the same bit.
    cap_d = (cap_q & ~clr_bits) | edge_det;
  end

  // Read mux sees pre-write register values, so read+write returns the old data.
  always_comb begin
    unique case (avs_address)
      ADDR_DATA_IN:  readdata_d = in_ext;
      ADDR_DATA_OUT: readdata_d = out_ext;
      ADDR_IRQ_MASK: readdata_d = mask_ext;
      default:       readdata_d = cap_ext;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      out_q      <= OUT_RESET;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
      rdvalid_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      prev_q    <= sync_last;
      out_q     <= out_d;
      mask_q    <= mask_d;
      cap_q     <= cap_d;
      rdvalid_q <= avs_read;
      irq_q     <= |(cap_q & mask_q);
      if (avs_read) begin
        readdata_q <= readdata_d;
      end
    end
  end

  assign avs_readdata      = readdata_q;
  assign avs_readdatavalid = rdvalid_q;
  assign irq               = irq_q;
  assign gpio_output       = out_q;

endmodule

// File: tb/tb_avalon_gpio_slave.sv
// Directed bench for avalon_gpio_slave with a cycle-level register model checked every cycle.
module tb_avalon_gpio_slave;

  localparam int unsigned W  = 10;
  localparam int unsigned S  = 2;
  localparam int unsigned EM = 0;
  localparam logic [W-1:0] OUT_RST = '0;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [1:0]    avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [3:0]    avs_byteenable = '0;
  logic [31:0]   avs_readdata;
  logic          avs_readdatavalid;
  logic          irq;
  logic [W-1:0]  gpio_input = '0;
  logic [W-1:0]  gpio_output;

  int checks = 0;
  int failures = 0;

  avalon_gpio_slave #(
    .WIDTH       (W),
    .SYNC_STAGES (S),
    .EDGE_MODE   (EM),
    .OUT_RESET   (OUT_RST)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .irq               (irq),
    .gpio_input        (gpio_input),
    .gpio_output       (gpio_output)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pin samples form a delay line; the synchronized value is the sample taken
  // S edges ago, and the edge detector compares it with the sample one edge older.
  logic [W-1:0] pins_m [S+1];
  logic [W-1:0] out_m = OUT_RST, mask_m = '0, cap_m = '0;
  logic         irq_m = 1'b0, rdv_m = 1'b0;
  logic [31:0]  rd_m = '0;

  initial for (int k = 0; k <= S; k++) pins_m[k] = '0;

  always @(posedge clk or negedge reset_n) begin
    logic [W-1:0] cur, prev, ed, clr;
    logic [31:0]  bm, wm;
    if (!reset_n) begin
      out_m = OUT_RST; mask_m = '0; cap_m = '0; irq_m = 1'b0; rdv_m = 1'b0; rd_m = '0;
      for (int k = 0; k <= S; k++) pins_m[k] = '0;
    end else begin
      cur  = pins_m[S-1];
      prev = pins_m[S];
      if (EM == 0)      ed = cur & ~prev;
      else if (EM == 1) ed = ~cur & prev;
      else              ed = cur ^ prev;
      bm = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
            {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
      wm = avs_writedata & bm;
      irq_m = (cap_m & mask_m) != '0;
      rdv_m = avs_read;
      if (avs_read) begin
        case (avs_address)
          2'd0:    rd_m = 32'(cur);
          2'd1:    rd_m = 32'(out_m);
          2'd2:    rd_m = 32'(mask_m);
          default: rd_m = 32'(cap_m);
        endcase
      end
      clr = '0;
      if (avs_write) begin
        if (avs_address == 2'd1) out_m  = (out_m  & ~bm[W-1:0]) | wm[W-1:0];
        if (avs_address == 2'd2) mask_m = (mask_m & ~bm[W-1:0]) | wm[W-1:0];
        if (avs_address == 2'd3) clr    = wm[W-1:0];
      end
      cap_m = (cap_m & ~clr) | ed;
      for (int k = S; k > 0; k--) pins_m[k] = pins_m[k-1];
      pins_m[0] = gpio_input;
    end
  end

  always @(negedge clk) begin
    chk("m_gpio_output", 32'(gpio_output), 32'(out_m));
    chk("m_irq", 32'(irq), 32'(irq_m));
    chk("m_rdvalid", 32'(avs_readdatavalid), 32'(rdv_m));
    if (rdv_m) chk("m_readdata", avs_readdata, rd_m);
  end

  // All bus tasks are entered at a negedge and return at a later negedge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic rd_expect(input string name, input logic [1:0] a, input logic [31:0] exp);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    chk({name, "_valid"}, 32'(avs_readdatavalid), 32'd1);
    chk(name, avs_readdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gpio_output", 32'(gpio_output), 32'(OUT_RST));
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rdvalid", 32'(avs_readdatavalid), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    rd_expect("rd_out_reset", 2'd1, 32'(OUT_RST));
    @(negedge clk);
    chk("rdvalid_single_pulse", 32'(avs_readdatavalid), 32'd0);

    bus_write(2'd1, 32'h0000_03FF, 4'b0001);
    chk("out_be0001", 32'(gpio_output), 32'h0FF);
    bus_write(2'd1, 32'h0000_03FF, 4'b0011);
    chk("out_be0011", 32'(gpio_output), 32'h3FF);
    bus_write(2'd1, 32'hFFFF_FC00, 4'b1111);
    chk("out_clear_all", 32'(gpio_output), 32'h000);
    bus_write(2'd1, 32'hFFFF_FFFF, 4'b1111);
    rd_expect("rd_out_upper_zero", 2'd1, 32'h0000_03FF);
    bus_write(2'd0, 32'h0000_0155, 4'b1111);
    rd_expect("rd_datain_ro", 2'd0, 32'h0);

    bus_write(2'd2, 32'h0000_0001, 4'b1111);
    rd_expect("rd_mask", 2'd2, 32'h0000_0001);
    gpio_input = 10'h005;
    repeat (3) @(negedge clk);
    chk("irq_not_yet", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_set", 32'(irq), 32'd1);
    rd_expect("rd_cap_rise", 2'd3, 32'h0000_0005);
    rd_expect("rd_datain", 2'd0, 32'h0000_0005);

    bus_write(2'd3, 32'h0000_0001, 4'b0001);
    chk("irq_lag", 32'(irq), 32'd1);
    @(negedge clk);
    chk("irq_cleared", 32'(irq), 32'd0);
    rd_expect("rd_cap_w1c", 2'd3, 32'h0000_0004);

    // Fall of bit2 is not captured in rising mode; then new rise collides with its clear.
    gpio_input = 10'h001;
    repeat (4) @(negedge clk);
    rd_expect("rd_cap_nofall", 2'd3, 32'h0000_0004);
    gpio_input = 10'h005;
    repeat (2) @(negedge clk);
    bus_write(2'd3, 32'h0000_0004, 4'b0001);
    rd_expect("rd_cap_edge_wins", 2'd3, 32'h0000_0004);
    bus_write(2'd3, 32'h0000_0004, 4'b0000);
    rd_expect("rd_cap_be_off", 2'd3, 32'h0000_0004);

    // Simultaneous read and write returns the pre-write value.
    avs_address = 2'd1; avs_writedata = 32'h155; avs_byteenable = 4'b1111;
    avs_read = 1'b1; avs_write = 1'b1;
    @(negedge clk);
    avs_read = 1'b0; avs_write = 1'b0;
    chk("rw_old_value", avs_readdata, 32'h0000_03FF);
    chk("rw_new_output", 32'(gpio_output), 32'h155);

    bus_write(2'd2, 32'h0000_0004, 4'b0001);
    gpio_input = 10'h000;
    repeat (2) @(negedge clk);
    chk("irq_bit2", 32'(irq), 32'd1);

    avs_address = 2'd1; avs_read = 1'b1;
    @(posedge clk);
    #1 reset_n = 1'b0;
    avs_read = 1'b0;
    #1;
    chk("rst_mid_rdvalid", 32'(avs_readdatavalid), 32'd0);
    chk("rst_mid_output", 32'(gpio_output), 32'(OUT_RST));
    chk("rst_mid_irq", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd_expect("rd_mask_after_rst", 2'd2, 32'h0);
    rd_expect("rd_cap_after_rst", 2'd3, 32'h0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
